shared_memory_response_collector: RTL

//  Return-side partner of the shared memory bank-conflict arbiter. Accepts one

---
 rtl/shared_memory_response_collector.sv | 133 +++++++++++++
 1 files changed

// File: rtl/shared_memory_response_collector.sv
// Collects per-lane bank read data for one warp request across arbiter replay
// cycles and returns the reassembled warp on a valid/ready response port.
module shared_memory_response_collector #(
    parameter int unsigned NUM_LANES  = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WARP_ID_W  = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [NUM_LANES-1:0]            req_mask,
    input  logic [WARP_ID_W-1:0]            req_warp_id,
    input  logic                            grant_valid,
    input  logic [NUM_LANES-1:0]            grant_lanes,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] bank_rdata,
    output logic [NUM_LANES-1:0]            pending_mask,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic [NUM_LANES*DATA_WIDTH-1:0] resp_data,
    output logic [NUM_LANES-1:0]            resp_mask,
    output logic [WARP_ID_W-1:0]            resp_warp_id,
    output logic [CNT_W-1:0]                replay_count,
    output logic                            grant_err
);

    typedef enum logic [1:0] {IDLE, COLLECT, RESPOND} state_t;

    state_t                          state_q, state_d;
    logic [NUM_LANES-1:0]            active_q, active_d;
    logic [NUM_LANES-1:0]            served_q, served_d;
    logic [NUM_LANES-1:0]            inflight_q, inflight_d;
    logic [NUM_LANES*DATA_WIDTH-1:0] data_q, data_d;
    logic [WARP_ID_W-1:0]            warp_id_q, warp_id_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            err_q, err_d;

    logic [NUM_LANES-1:0]            open_lanes;
    logic [NUM_LANES-1:0]            new_lanes;
    logic [NUM_LANES-1:0]            served_nxt;

    // Lanes still eligible for a grant: neither captured nor awaiting data.
    assign open_lanes = active_q & ~served_q & ~inflight_q;

    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        served_d   = served_q;
        inflight_d = inflight_q;
        data_d     = data_q;
        warp_id_d  = warp_id_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        new_lanes  = '0;
        served_nxt = served_q | inflight_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    active_d   = req_mask;
                    warp_id_d  = req_warp_id;
                    served_d   = '0;
                    inflight_d = '0;
                    data_d     = '0;
                    cnt_d      = '0;
                    state_d    = (req_mask == '0) ? RESPOND : COLLECT;
                end
            end
            COLLECT: begin
                // Data for last cycle's grants arrives now; new grants overlap it.
                for (int i = 0; i < int'(NUM_LANES); i++) begin
                    if (inflight_q[i]) begin
                        data_d[i*DATA_WIDTH +: DATA_WIDTH] = bank_rdata[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                if (grant_valid) begin
                    new_lanes = grant_lanes & open_lanes;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                served_d   = served_nxt;
                inflight_d = new_lanes;
                if (served_nxt == active_q) begin
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_valid && ((state_q != COLLECT) || ((grant_lanes & ~open_lanes) != '0))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            active_q   <= '0;
            served_q   <= '0;
            inflight_q <= '0;
            data_q     <= '0;
            warp_id_q  <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            served_q   <= served_d;
            inflight_q <= inflight_d;
            data_q     <= data_d;
            warp_id_q  <= warp_id_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = (state_q == RESPOND);
    assign pending_mask = open_lanes;
    assign resp_data    = data_q;
    assign resp_mask    = active_q;
    assign resp_warp_id = warp_id_q;
    assign replay_count = cnt_q;
    assign grant_err    = err_q;

endmodule
